traffic_loopback_checker: RTL and testbench

TRAFFIC_LOOPBACK_CHECKER -- requirements
Module: traffic_loopback_checker

---
 rtl/traffic_gen_pkg.sv | 18 +
 rtl/traffic_beat_cmp.sv | 26 ++
 rtl/traffic_loopback_checker.sv | 172 +++++++++++++++++
 tb/tb_traffic_loopback_checker.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_gen_pkg.sv
// Shared types, widths and parameter checks for the loopback traffic checker.
package traffic_gen_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBody,
    StHalt
  } state_e;

  localparam int unsigned TsWidth  = 32;
  localparam int unsigned CntWidth = 32;
  localparam int unsigned SumWidth = 64;

  function automatic bit dwidth_legal(input int unsigned w);
    return (w == 64) || (w == 128) || (w == 256) || (w == 512);
  endfunction

endpackage

// File: rtl/traffic_beat_cmp.sv
// Combinational beat comparator: keep and last must match exactly, data only on kept bytes.
module traffic_beat_cmp #(
  parameter int unsigned DWIDTH = 512
) (
  input  logic [DWIDTH-1:0]   rx_data,
  input  logic [DWIDTH/8-1:0] rx_keep,
  input  logic                rx_last,
  input  logic [DWIDTH-1:0]   exp_data,
  input  logic [DWIDTH/8-1:0] exp_keep,
  input  logic                exp_last,
  output logic                beat_mismatch
);

  localparam int unsigned KeepWidth = DWIDTH / 8;

  logic [KeepWidth-1:0] byte_diff;

  always_comb begin
    byte_diff = '0;
    for (int i = 0; i < KeepWidth; i++) begin
      byte_diff[i] = exp_keep[i] && (rx_data[8*i +: 8] != exp_data[8*i +: 8]);
    end
    beat_mismatch = (rx_keep != exp_keep) || (rx_last != exp_last) || (|byte_diff);
  end

endmodule

// File: rtl/traffic_loopback_checker.sv
// Joins a received stream with its expected copy, flags mismatches and gathers
// packet count, elapsed time and per-packet latency statistics.
module traffic_loopback_checker
  import traffic_gen_pkg::*;
#(
  parameter int unsigned DWIDTH      = 512,
  parameter int unsigned HALT_ON_ERR = 0,
  parameter int unsigned TS_OFFSET   = 0
) (
  input  logic                  traffic_clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic [TsWidth-1:0]    time_cnt,

  input  logic [DWIDTH-1:0]     from_app_tdata,
  input  logic [DWIDTH/8-1:0]   from_app_tkeep,
  input  logic                  from_app_tlast,
  input  logic                  from_app_tvalid,
  output logic                  from_app_tready,

  input  logic [DWIDTH-1:0]     from_cmp_fifo_tdata,
  input  logic [DWIDTH/8-1:0]   from_cmp_fifo_tkeep,
  input  logic                  from_cmp_fifo_tlast,
  input  logic                  from_cmp_fifo_tvalid,
  output logic                  from_cmp_fifo_tready,

  output logic                  mismatch,
  output logic [CntWidth-1:0]   mismatch_pkt,
  output logic [CntWidth-1:0]   pkt_cnt_rx,
  output logic [TsWidth-1:0]    rx_timeElapse,
  output logic [SumWidth-1:0]   rx_timestamp_sum,
  output logic [TsWidth-1:0]    rx_latency_max
);

  if (!dwidth_legal(DWIDTH)) begin : gen_bad_dwidth
    $error("DWIDTH must be 64, 128, 256 or 512");
  end
  if (TS_OFFSET + 4 > DWIDTH / 8) begin : gen_bad_ts_offset
    $error("TS_OFFSET places the timestamp outside the beat");
  end

  state_e              state_q, state_d;
  logic [TsWidth-1:0]  pkt_ts_q, pkt_ts_d;
  logic                started_q, started_d;
  logic [TsWidth-1:0]  start_q, start_d;
  logic                mismatch_q, mismatch_d;
  logic [CntWidth-1:0] mismatch_pkt_q, mismatch_pkt_d;
  logic [CntWidth-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [TsWidth-1:0]  elapse_q, elapse_d;
  logic [SumWidth-1:0] sum_q, sum_d;
  logic [TsWidth-1:0]  max_q, max_d;

  logic               halted;
  logic               accept;
  logic               beat_mismatch;
  logic [TsWidth-1:0] beat_ts;
  logic [TsWidth-1:0] ts_eff;
  logic [TsWidth-1:0] start_eff;
  logic [TsWidth-1:0] latency;

  traffic_beat_cmp #(
    .DWIDTH (DWIDTH)
  ) u_beat_cmp (
    .rx_data       (from_app_tdata),
    .rx_keep       (from_app_tkeep),
    .rx_last       (from_app_tlast),
    .exp_data      (from_cmp_fifo_tdata),
    .exp_keep      (from_cmp_fifo_tkeep),
    .exp_last      (from_cmp_fifo_tlast),
    .beat_mismatch (beat_mismatch)
  );

  assign halted = (state_q == StHalt);

  // Each side is ready exactly when the other side offers a beat.
  assign from_app_tready      = from_cmp_fifo_tvalid & ~halted & ~rst;
  assign from_cmp_fifo_tready = from_app_tvalid & ~halted & ~rst;
  assign accept               = from_app_tvalid & from_cmp_fifo_tvalid & ~halted;

  assign beat_ts   = from_cmp_fifo_tdata[8*TS_OFFSET +: TsWidth];
  // A single-beat packet uses its own timestamp; the first beat also seeds the start time.
  assign ts_eff    = (state_q == StIdle) ? beat_ts : pkt_ts_q;
  assign start_eff = started_q ? start_q : time_cnt;
  assign latency   = time_cnt - ts_eff;

  always_comb begin
    state_d        = state_q;
    pkt_ts_d       = pkt_ts_q;
    started_d      = started_q;
    start_d        = start_q;
    mismatch_d     = mismatch_q;
    mismatch_pkt_d = mismatch_pkt_q;
    pkt_cnt_d      = pkt_cnt_q;
    elapse_d       = elapse_q;
    sum_d          = sum_q;
    max_d          = max_q;

    if (clr) begin
      state_d        = StIdle;
      pkt_ts_d       = '0;
      started_d      = 1'b0;
      start_d        = '0;
      mismatch_d     = 1'b0;
      mismatch_pkt_d = '0;
      pkt_cnt_d      = '0;
      elapse_d       = '0;
      sum_d          = '0;
      max_d          = '0;
    end else if (accept) begin
      if (!started_q) begin
        started_d = 1'b1;
        start_d   = time_cnt;
      end
      if (state_q == StIdle) begin
        pkt_ts_d = beat_ts;
      end
      if (beat_mismatch) begin
        mismatch_d = 1'b1;
        if (!mismatch_q) begin
          mismatch_pkt_d = pkt_cnt_q;
        end
      end
      if (from_cmp_fifo_tlast) begin
        pkt_cnt_d = pkt_cnt_q + 32'd1;
        elapse_d  = time_cnt - start_eff;
        sum_d     = sum_q + {32'd0, latency};
        if (latency > max_q) begin
          max_d = latency;
        end
      end
      if (beat_mismatch && (HALT_ON_ERR != 0)) begin
        state_d = StHalt;
      end else begin
        state_d = from_cmp_fifo_tlast ? StIdle : StBody;
      end
    end
  end

  always_ff @(posedge traffic_clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      pkt_ts_q       <= '0;
      started_q      <= 1'b0;
      start_q        <= '0;
      mismatch_q     <= 1'b0;
      mismatch_pkt_q <= '0;
      pkt_cnt_q      <= '0;
      elapse_q       <= '0;
      sum_q          <= '0;
      max_q          <= '0;
    end else begin
      state_q        <= state_d;
      pkt_ts_q       <= pkt_ts_d;
      started_q      <= started_d;
      start_q        <= start_d;
      mismatch_q     <= mismatch_d;
      mismatch_pkt_q <= mismatch_pkt_d;
      pkt_cnt_q      <= pkt_cnt_d;
      elapse_q       <= elapse_d;
      sum_q          <= sum_d;
      max_q          <= max_d;
    end
  end

  assign mismatch         = mismatch_q;
  assign mismatch_pkt     = mismatch_pkt_q;
  assign pkt_cnt_rx       = pkt_cnt_q;
  assign rx_timeElapse    = elapse_q;
  assign rx_timestamp_sum = sum_q;
  assign rx_latency_max   = max_q;

endmodule

// File: tb/tb_traffic_loopback_checker.sv
// Randomised bench for traffic_loopback_checker against a packet-level reference model.
module tb_traffic_loopback_checker;

  localparam int unsigned DW     = 512;
  localparam int unsigned KW     = DW / 8;
  localparam int unsigned TS_OFF = 0;

  logic          clk = 1'b0;
  logic          rst;
  logic          clr;
  logic [31:0]   time_cnt;
  logic [DW-1:0] app_tdata, cmp_tdata;
  logic [KW-1:0] app_tkeep, cmp_tkeep;
  logic          app_tlast, cmp_tlast, app_tvalid, cmp_tvalid;

  logic          d0_app_tready, d0_cmp_tready, d0_mismatch;
  logic [31:0]   d0_mismatch_pkt, d0_pkt_cnt, d0_elapse, d0_max;
  logic [63:0]   d0_sum;
  logic          d1_app_tready, d1_cmp_tready, d1_mismatch;
  logic [31:0]   d1_mismatch_pkt, d1_pkt_cnt, d1_elapse, d1_max;
  logic [63:0]   d1_sum;

  int n_checks = 0;
  int n_fail   = 0;

  // Packet-level reference state
  logic [31:0] m_cnt, m_max, m_elapse, m_start, m_mis_pkt;
  logic [63:0] m_sum;
  bit          m_mis, m_started;

  always #5 clk = ~clk;

  traffic_loopback_checker #(
    .DWIDTH (DW), .HALT_ON_ERR (0), .TS_OFFSET (TS_OFF)
  ) dut0 (
    .traffic_clk (clk), .rst (rst), .clr (clr), .time_cnt (time_cnt),
    .from_app_tdata (app_tdata), .from_app_tkeep (app_tkeep), .from_app_tlast (app_tlast),
    .from_app_tvalid (app_tvalid), .from_app_tready (d0_app_tready),
    .from_cmp_fifo_tdata (cmp_tdata), .from_cmp_fifo_tkeep (cmp_tkeep),
    .from_cmp_fifo_tlast (cmp_tlast), .from_cmp_fifo_tvalid (cmp_tvalid),
    .from_cmp_fifo_tready (d0_cmp_tready),
    .mismatch (d0_mismatch), .mismatch_pkt (d0_mismatch_pkt), .pkt_cnt_rx (d0_pkt_cnt),
    .rx_timeElapse (d0_elapse), .rx_timestamp_sum (d0_sum), .rx_latency_max (d0_max)
  );

  traffic_loopback_checker #(
    .DWIDTH (DW), .HALT_ON_ERR (1), .TS_OFFSET (TS_OFF)
  ) dut1 (
    .traffic_clk (clk), .rst (rst), .clr (clr), .time_cnt (time_cnt),
    .from_app_tdata (app_tdata), .from_app_tkeep (app_tkeep), .from_app_tlast (app_tlast),
    .from_app_tvalid (app_tvalid), .from_app_tready (d1_app_tready),
    .from_cmp_fifo_tdata (cmp_tdata), .from_cmp_fifo_tkeep (cmp_tkeep),
    .from_cmp_fifo_tlast (cmp_tlast), .from_cmp_fifo_tvalid (cmp_tvalid),
    .from_cmp_fifo_tready (d1_cmp_tready),
    .mismatch (d1_mismatch), .mismatch_pkt (d1_mismatch_pkt), .pkt_cnt_rx (d1_pkt_cnt),
    .rx_timeElapse (d1_elapse), .rx_timestamp_sum (d1_sum), .rx_latency_max (d1_max)
  );

  task automatic model_clear();
    m_cnt = 0; m_max = 0; m_elapse = 0; m_start = 0; m_mis_pkt = 0;
    m_sum = 0; m_mis = 0; m_started = 0;
  endtask

  task automatic idle_inputs();
    app_tvalid = 0; cmp_tvalid = 0; app_tlast = 0; cmp_tlast = 0;
  endtask

  task automatic do_clr();
    clr = 1;
    @(negedge clk);
    clr = 0;
    model_clear();
  endtask

  // err_kind: 0 none, 1 kept byte 5 differs, 2 masked byte 5 differs, 3 keep bit 10 differs
  task automatic drive_beat(input int b, input int nbeats, input logic [31:0] ts,
                            input logic [31:0] tf, input logic [31:0] tl,
                            input int err_beat, input int err_kind);
    logic [DW-1:0] d, rd;
    logic [KW-1:0] k, rk;
    for (int w = 0; w < DW / 32; w++) d[32*w +: 32] = $urandom;
    k = {$urandom, $urandom};
    if (b == 0) d[8*TS_OFF +: 32] = ts;
    if (b == err_beat && err_kind == 1) k[5] = 1'b1;
    if (b == err_beat && err_kind == 2) k[5] = 1'b0;
    rd = d;
    rk = k;
    for (int i = 0; i < KW; i++) if (!k[i]) rd[8*i +: 8] = 8'($urandom);
    if (b == err_beat && (err_kind == 1 || err_kind == 2)) rd[47:40] = d[47:40] ^ 8'hA5;
    if (b == err_beat && err_kind == 3) rk[10] = ~k[10];
    cmp_tdata = d;  cmp_tkeep = k;  cmp_tlast = (b == nbeats - 1);
    app_tdata = rd; app_tkeep = rk; app_tlast = (b == nbeats - 1);
    app_tvalid = 1; cmp_tvalid = 1;
    time_cnt = (b == nbeats - 1) ? tl : tf;
  endtask

  // Sends a whole packet one beat per cycle (dut0 always accepts) and updates the model.
  task automatic send_pkt(input int nbeats, input logic [31:0] ts, input logic [31:0] tf,
                          input logic [31:0] tl, input int err_beat, input int err_kind);
    for (int b = 0; b < nbeats; b++) begin
      drive_beat(b, nbeats, ts, tf, tl, err_beat, err_kind);
      if (!m_started) begin
        m_started = 1;
        m_start = time_cnt;
      end
      if (b == err_beat && (err_kind == 1 || err_kind == 3)) begin
        if (!m_mis) m_mis_pkt = m_cnt;
        m_mis = 1;
      end
      @(negedge clk);
    end
    m_cnt++;
    m_sum = m_sum + 64'(tl - ts);
    if ((tl - ts) > m_max) m_max = tl - ts;
    m_elapse = tl - m_start;
    idle_inputs();
  endtask

  task automatic test_reset();
    rst = 1; clr = 0; time_cnt = 32'h1234;
    app_tvalid = 1; cmp_tvalid = 1;
    @(negedge clk);
    n_checks++;
    if ({d0_app_tready, d0_cmp_tready, d1_app_tready, d1_cmp_tready} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_tready got %b want 0000",
               {d0_app_tready, d0_cmp_tready, d1_app_tready, d1_cmp_tready});
    end
    n_checks++;
    if ({d0_mismatch, d0_mismatch_pkt, d0_pkt_cnt, d0_elapse, d0_sum, d0_max} !== '0) begin
      n_fail++;
      $display("FAIL reset_stats got cnt=%0d sum=%0d max=%0d el=%0d mis=%b want all 0",
               d0_pkt_cnt, d0_sum, d0_max, d0_elapse, d0_mismatch);
    end
    idle_inputs();
    @(negedge clk);
    rst = 0;
    model_clear();
    @(negedge clk);
  endtask

  task automatic test_basic();
    do_clr();
    for (int p = 0; p < 3; p++) send_pkt(4, 32'd100, 32'd100, 32'd130, -1, 0);
    n_checks++;
    if (d0_pkt_cnt !== 32'd3) begin
      n_fail++; $display("FAIL basic_cnt got %0d want 3", d0_pkt_cnt);
    end
    n_checks++;
    if (d0_mismatch !== 1'b0) begin
      n_fail++; $display("FAIL basic_mismatch got %b want 0", d0_mismatch);
    end
    n_checks++;
    if (d0_sum !== 64'd90) begin
      n_fail++; $display("FAIL basic_sum got %0d want 90", d0_sum);
    end
    n_checks++;
    if (d0_max !== 32'd30) begin
      n_fail++; $display("FAIL basic_max got %0d want 30", d0_max);
    end
    n_checks++;
    if (d0_elapse !== 32'd30) begin
      n_fail++; $display("FAIL basic_elapse got %0d want 30", d0_elapse);
    end
  endtask

  task automatic test_one_sided();
    app_tvalid = 1; cmp_tvalid = 0; app_tlast = 1;
    app_tdata = '1; app_tkeep = '1; time_cnt = 32'hDEAD;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_checks++;
      if (d0_cmp_tready !== 1'b1 || d0_app_tready !== 1'b0) begin
        n_fail++;
        $display("FAIL one_sided_ready cyc %0d got cmp=%b app=%b want cmp=1 app=0",
                 c, d0_cmp_tready, d0_app_tready);
      end
    end
    idle_inputs();
    n_checks++;
    if (d0_pkt_cnt !== m_cnt || d0_sum !== m_sum || d0_elapse !== m_elapse) begin
      n_fail++;
      $display("FAIL one_sided_stats got cnt=%0d sum=%0d el=%0d want cnt=%0d sum=%0d el=%0d",
               d0_pkt_cnt, d0_sum, d0_elapse, m_cnt, m_sum, m_elapse);
    end
  endtask

  task automatic test_mismatch();
    do_clr();
    send_pkt(4, 32'd10, 32'd10, 32'd20, -1, 0);
    send_pkt(4, 32'd10, 32'd10, 32'd20, 1, 1);
    send_pkt(4, 32'd10, 32'd10, 32'd20, -1, 0);
    n_checks++;
    if (d0_mismatch !== 1'b1 || d0_mismatch_pkt !== 32'd1) begin
      n_fail++;
      $display("FAIL mismatch_kept got mis=%b pkt=%0d want mis=1 pkt=1",
               d0_mismatch, d0_mismatch_pkt);
    end
    n_checks++;
    if (d0_pkt_cnt !== 32'd3) begin
      n_fail++; $display("FAIL mismatch_cnt got %0d want 3", d0_pkt_cnt);
    end
    do_clr();
    send_pkt(4, 32'd10, 32'd10, 32'd20, -1, 0);
    send_pkt(4, 32'd10, 32'd10, 32'd20, 1, 2);
    n_checks++;
    if (d0_mismatch !== 1'b0) begin
      n_fail++; $display("FAIL mismatch_masked got %b want 0", d0_mismatch);
    end
  endtask

  task automatic test_wrap();
    do_clr();
    send_pkt(3, 32'hFFFF_FFF0, 32'hFFFF_FFF8, 32'h0000_0010, -1, 0);
    n_checks++;
    if (d0_max !== 32'h20 || d0_sum !== 64'h20) begin
      n_fail++;
      $display("FAIL wrap_latency got max=%h sum=%h want max=20 sum=20", d0_max, d0_sum);
    end
  endtask

  task automatic test_halt();
    do_clr();
    send_pkt(2, 32'd5, 32'd5, 32'd9, -1, 0);
    for (int b = 0; b < 3; b++) begin
      drive_beat(b, 4, 32'd5, 32'd5, 32'd9, 2, 1);
      @(negedge clk);
    end
    drive_beat(3, 4, 32'd5, 32'd5, 32'd9, 2, 1);
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (d1_app_tready !== 1'b0 || d1_cmp_tready !== 1'b0) begin
        n_fail++;
        $display("FAIL halt_ready cyc %0d got app=%b cmp=%b want 0 0",
                 c, d1_app_tready, d1_cmp_tready);
      end
      @(negedge clk);
    end
    n_checks++;
    if (d1_mismatch !== 1'b1 || d1_mismatch_pkt !== 32'd1 || d1_pkt_cnt !== 32'd1) begin
      n_fail++;
      $display("FAIL halt_stats got mis=%b mpkt=%0d cnt=%0d want 1 1 1",
               d1_mismatch, d1_mismatch_pkt, d1_pkt_cnt);
    end
    idle_inputs();
    do_clr();
    app_tvalid = 1; cmp_tvalid = 0;
    #1;
    n_checks++;
    if (d1_cmp_tready !== 1'b1 || d1_app_tready !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_clr_ready got cmp=%b app=%b want 1 0", d1_cmp_tready, d1_app_tready);
    end
    n_checks++;
    if ({d1_mismatch, d1_mismatch_pkt, d1_pkt_cnt, d1_sum, d1_max, d1_elapse} !== '0) begin
      n_fail++;
      $display("FAIL halt_clr_stats got mis=%b cnt=%0d sum=%0d want 0",
               d1_mismatch, d1_pkt_cnt, d1_sum);
    end
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_clr_mid();
    do_clr();
    drive_beat(0, 4, 32'd1000, 32'd1000, 32'd2000, -1, 0);
    @(negedge clk);
    drive_beat(1, 4, 32'd1000, 32'd1000, 32'd2000, 1, 1);
    @(negedge clk);
    drive_beat(3, 4, 32'd1000, 32'd1000, 32'd2000, 3, 1);
    clr = 1;
    @(negedge clk);
    clr = 0;
    idle_inputs();
    model_clear();
    send_pkt(1, 32'd50, 32'd70, 32'd70, -1, 0);
    n_checks++;
    if (d0_pkt_cnt !== 32'd1 || d0_elapse !== 32'd0 || d0_mismatch !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_mid got cnt=%0d el=%0d mis=%b want 1 0 0",
               d0_pkt_cnt, d0_elapse, d0_mismatch);
    end
    n_checks++;
    if (d0_sum !== 64'd20 || d0_max !== 32'd20) begin
      n_fail++; $display("FAIL clr_mid_lat got sum=%0d max=%0d want 20 20", d0_sum, d0_max);
    end
  endtask

  task automatic test_rst_mid();
    drive_beat(0, 3, 32'd400, 32'd400, 32'd900, -1, 0);
    @(negedge clk);
    drive_beat(1, 3, 32'd400, 32'd400, 32'd900, -1, 0);
    @(negedge clk);
    idle_inputs();
    rst = 1;
    @(negedge clk);
    rst = 0;
    model_clear();
    @(negedge clk);
    send_pkt(1, 32'd7, 32'd20, 32'd20, -1, 0);
    n_checks++;
    if (d0_pkt_cnt !== 32'd1 || d0_elapse !== 32'd0) begin
      n_fail++;
      $display("FAIL rst_mid got cnt=%0d el=%0d want 1 0", d0_pkt_cnt, d0_elapse);
    end
    n_checks++;
    if (d0_sum !== 64'd13 || d0_max !== 32'd13) begin
      n_fail++; $display("FAIL rst_mid_lat got sum=%0d max=%0d want 13 13", d0_sum, d0_max);
    end
  endtask

  task automatic test_random();
    do_clr();
    for (int p = 0; p < 30; p++) begin
      int nb, eb, ek;
      logic [31:0] ts, tf, tl;
      nb = $urandom_range(1, 5);
      ts = $urandom;
      tf = ts + $urandom_range(0, 50);
      tl = tf + $urandom_range(0, 5000);
      ek = $urandom_range(0, 9);
      if (ek > 3) ek = 0;
      eb = $urandom_range(0, nb - 1);
      send_pkt(nb, ts, tf, tl, eb, ek);
      if ($urandom_range(0, 2) == 0) @(negedge clk);
      n_checks++;
      if (d0_pkt_cnt !== m_cnt || d0_sum !== m_sum || d0_max !== m_max) begin
        n_fail++;
        $display("FAIL rand_stats pkt %0d got cnt=%0d sum=%0d max=%0d want %0d %0d %0d",
                 p, d0_pkt_cnt, d0_sum, d0_max, m_cnt, m_sum, m_max);
      end
      n_checks++;
      if (d0_elapse !== m_elapse) begin
        n_fail++;
        $display("FAIL rand_elapse pkt %0d got %0d want %0d", p, d0_elapse, m_elapse);
      end
      n_checks++;
      if (d0_mismatch !== m_mis || d0_mismatch_pkt !== m_mis_pkt) begin
        n_fail++;
        $display("FAIL rand_mismatch pkt %0d got mis=%b mpkt=%0d want %b %0d",
                 p, d0_mismatch, d0_mismatch_pkt, m_mis, m_mis_pkt);
      end
    end
  endtask

  initial begin
    clr = 0; rst = 1; time_cnt = 0;
    app_tdata = '0; cmp_tdata = '0; app_tkeep = '0; cmp_tkeep = '0;
    idle_inputs();
    test_reset();
    test_basic();
    test_one_sided();
    test_mismatch();
    test_wrap();
    test_halt();
    test_clr_mid();
    test_rst_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
